// File: rtl/qkv_phase_ctrl.sv
// qkv_phase_ctrl: phase FSM and port arbiter for the QKV result SRAMs.
// Optional projection cycle counter: define QKV_PHASE_PERF_CNT_EN.
module qkv_phase_ctrl #(
  parameter int N_CH     = 3,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 128,
  parameter int READ_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     fin,
  input  logic [N_CH-1:0]          proj_web,
  input  logic [N_CH*ADDR_W-1:0]   proj_addr,
  input  logic [N_CH-1:0]          proj_finished,
  input  logic [N_CH*ADDR_W-1:0]   attn_addr,
  input  logic                     attn_done,
  input  logic [ADDR_W-1:0]        fin_addr,
  input  logic                     fin_ren,
  input  logic [$clog2(N_CH)-1:0]  fin_sel,
  input  logic [N_CH*DATA_W-1:0]   mem_dout,
  output logic [N_CH-1:0]          mem_web,
  output logic [N_CH*ADDR_W-1:0]   mem_addr,
  output logic                     attn_start,
  output logic [2:0]               phase,
  output logic                     fin_rvalid,
  output logic [DATA_W-1:0]        fin_rdata,
  output logic [31:0]              proj_cycles
);

  localparam int SW = $clog2(N_CH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROJ  = 3'd1,
    START = 3'd2,
    ATTN  = 3'd3,
    DONE  = 3'd4,
    READ  = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [N_CH-1:0] done_q;
  logic [N_CH-1:0] done_nx;

  logic              acc;
  logic [READ_LAT-1:0] vld_q;
  logic [SW-1:0]     sel_q [READ_LAT];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] lane;

  assign phase = state;

  // State register and sticky per-channel completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= '0;
    end else begin
      state  <= state_nx;
      done_q <= done_nx;
    end
  end

  // Next state and memory port ownership
  always_comb begin
    state_nx   = state;
    done_nx    = done_q;
    mem_web    = '1;
    mem_addr   = '0;
    attn_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (fin)     state_nx = READ;
        else if (en) state_nx = PROJ;
      end
      PROJ: begin
        mem_addr = proj_addr;
        if (en) mem_web = proj_web;
        done_nx = done_q | proj_finished;
        if (&done_nx) state_nx = START;
      end
      START: begin
        attn_start = 1'b1;
        mem_addr   = attn_addr;
        state_nx   = ATTN;
      end
      ATTN: begin
        mem_addr = attn_addr;
        if (attn_done) state_nx = DONE;
      end
      DONE: begin
        if (fin) state_nx = READ;
      end
      READ: begin
        mem_addr = {N_CH{fin_addr}};
        if (!fin) begin
          state_nx = IDLE;
          done_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign acc = (state == READ) && fin_ren;

  // Latency-matched valid/select pipe plus held read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      rdata_q <= '0;
      for (int k = 0; k < READ_LAT; k++) sel_q[k] <= '0;
    end else begin
      vld_q[0] <= acc;
      sel_q[0] <= fin_sel;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        sel_q[k] <= sel_q[k-1];
      end
      rdata_q <= fin_rdata;
    end
  end

  // Select the returning lane for the host
  always_comb begin
    lane = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_q[READ_LAT-1] == SW'(i))
        lane = mem_dout[i*DATA_W +: DATA_W];
    end
  end

  assign fin_rvalid = vld_q[READ_LAT-1];
  assign fin_rdata  = fin_rvalid ? lane : rdata_q;

`ifdef QKV_PHASE_PERF_CNT_EN
  logic [31:0] cyc_q;

  // Saturating count of enabled projection cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (state == IDLE && state_nx == PROJ) begin
      cyc_q <= '0;
    end else if (state == PROJ && en && cyc_q != 32'hFFFF_FFFF) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign proj_cycles = cyc_q;
`else
  assign proj_cycles = '0;
`endif

endmodule

// File: tb/tb_qkv_phase_ctrl.sv
// tb_qkv_phase_ctrl: random and directed stimulus against a
// phase/scoreboard reference model with a behavioural SRAM.
module tb_qkv_phase_ctrl;

  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 128;
  localparam int RL = 2;

  logic            clk = 0;
  logic            rst_n;
  logic            en;
  logic            fin;
  logic [N-1:0]    proj_web;
  logic [N*AW-1:0] proj_addr;
  logic [N-1:0]    proj_finished;
  logic [N*AW-1:0] attn_addr;
  logic            attn_done;
  logic [AW-1:0]   fin_addr;
  logic            fin_ren;
  logic [1:0]      fin_sel;
  logic [N*DW-1:0] mem_dout;
  logic [N-1:0]    mem_web;
  logic [N*AW-1:0] mem_addr;
  logic            attn_start;
  logic [2:0]      phase;
  logic            fin_rvalid;
  logic [DW-1:0]   fin_rdata;
  logic [31:0]     proj_cycles;

  int checks = 0;
  int errors = 0;

  qkv_phase_ctrl #(
    .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fin(fin),
    .proj_web(proj_web), .proj_addr(proj_addr),
    .proj_finished(proj_finished), .attn_addr(attn_addr),
    .attn_done(attn_done), .fin_addr(fin_addr),
    .fin_ren(fin_ren), .fin_sel(fin_sel), .mem_dout(mem_dout),
    .mem_web(mem_web), .mem_addr(mem_addr),
    .attn_start(attn_start), .phase(phase),
    .fin_rvalid(fin_rvalid), .fin_rdata(fin_rdata),
    .proj_cycles(proj_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dat(input int ch, input logic [AW-1:0] a);
    logic [31:0] c;
    logic [31:0] x;
    c = 32'(ch);
    x = 32'(a);
    return {c, x * 32'h9E37_79B9, ~x, c * 32'd131 + x};
  endfunction

  // Behavioural SRAM: data returns RL cycles after the address
  logic [N*AW-1:0] a_d1 = '0;
  logic [N*AW-1:0] a_d2 = '0;
  always @(posedge clk) begin
    a_d2 <= a_d1;
    a_d1 <= mem_addr;
  end
  always_comb begin
    mem_dout = '0;
    for (int i = 0; i < N; i++)
      mem_dout[i*DW +: DW] = dat(i, a_d2[i*AW +: AW]);
  end

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  int            m_ph;
  logic [N-1:0]  m_done;
  int            cyc = 0;
  int            due_q[$];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] last_rd;
  logic [31:0]   m_cnt;
  bit            chk_on = 0;

  task automatic model_reset();
    m_ph = 0;
    m_done = '0;
    due_q.delete();
    dq.delete();
    last_rd = '0;
    m_cnt = '0;
  endtask

  task automatic model_step();
    int nx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nx = m_ph;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      last_rd = dq[0];
      void'(due_q.pop_front());
      void'(dq.pop_front());
    end
    if (m_ph == 5 && fin_ren) begin
      due_q.push_back(cyc + RL);
      dq.push_back(dat(int'(fin_sel), fin_addr));
    end
    case (m_ph)
      0: nx = fin ? 5 : (en ? 1 : 0);
      1: begin
        m_done = m_done | proj_finished;
        if (m_done == '1) nx = 2;
      end
      2: nx = 3;
      3: if (attn_done) nx = 4;
      4: if (fin) nx = 5;
      5: if (!fin) begin
        nx = 0;
        m_done = '0;
      end
      default: nx = 0;
    endcase
    if (m_ph == 0 && nx == 1) m_cnt = '0;
    else if (m_ph == 1 && en && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    m_ph = nx;
    cyc++;
  endtask

  task automatic compare_all();
    logic [N-1:0]    ew;
    logic [N*AW-1:0] ea;
    logic            rv;
    logic [31:0]     ec;
    ew = '1;
    ea = '0;
    if (m_ph == 1) begin
      ea = proj_addr;
      if (en) ew = proj_web;
    end else if (m_ph == 2 || m_ph == 3) begin
      ea = attn_addr;
    end else if (m_ph == 5) begin
      ea = {N{fin_addr}};
    end
    rv = due_q.size() > 0 && due_q[0] == cyc;
`ifdef QKV_PHASE_PERF_CNT_EN
    ec = m_cnt;
`else
    ec = '0;
`endif
    chk("phase", phase, m_ph);
    chk("web", mem_web, ew);
    chk("addr", mem_addr, ea);
    chk("start", attn_start, m_ph == 2);
    chk("rvalid", fin_rvalid, rv);
    chk("rdata", fin_rdata, rv ? dq[0] : last_rd);
    chk("pcyc", proj_cycles, ec);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) compare_all();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    en = 0; fin = 0; proj_web = '1; proj_addr = '0;
    proj_finished = '0; attn_addr = '0; attn_done = 0;
    fin_addr = '0; fin_ren = 0; fin_sel = '0;
  endtask

  initial begin
    quiet();
    rst_n = 0;
    model_reset();
    #2;
    chk("rst_phase", phase, 3'd0);
    chk("rst_web", mem_web, 3'b111);
    chk("rst_addr", mem_addr, '0);
    chk("rst_start", attn_start, 1'b0);
    chk("rst_rvalid", fin_rvalid, 1'b0);
    chk("rst_rdata", fin_rdata, '0);
    chk("rst_pcyc", proj_cycles, '0);
    chk_on = 1;
    repeat (2) step();
    rst_n = 1;

    // Staggered finishes with write pause and ATTN isolation
    for (int c = 0; c < 36; c++) begin
      en = 1;
      proj_web = 3'b000;
      if (c == 5) en = 0;
      proj_finished = (c == 10) ? 3'b001 :
                      (c == 20) ? 3'b100 :
                      (c == 30) ? 3'b010 : 3'b000;
      attn_addr = {7'h00, 7'h15, 7'h00};
      #3;
      if (c == 5) chk("pause_web", mem_web, 3'b111);
      if (c == 6) chk("resume_web", mem_web, 3'b000);
      if (c == 30) chk("stag_nostart", attn_start, 1'b0);
      if (c == 31) chk("stag_start", attn_start, 1'b1);
      if (c == 32) chk("stag_attn", phase, 3'd3);
      if (c == 33) chk("attn_web", mem_web, 3'b111);
      step();
    end
    attn_done = 1;
    step();
    quiet();
    #3 chk("attn_done", phase, 3'd4);
    fin = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      fin = 1;
      fin_ren = 1;
      fin_sel = 2'(i);
      fin_addr = 7'(5 + i);
      step();
    end
    fin_ren = 0;
    repeat (4) step();
    fin = 0;
    repeat (2) step();

    // Reset mid-PROJ, then a new run needs all three finishes
    en = 1;
    step();
    proj_finished = 3'b011;
    step();
    proj_finished = 3'b000;
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("midrst_phase", phase, 3'd0);
    chk("midrst_web", mem_web, 3'b111);
    step();
    rst_n = 1;
    en = 1;
    step();
    proj_finished = 3'b100;
    repeat (3) step();
    chk("need_all", phase, 3'd1);
    proj_finished = 3'b011;
    step();
    proj_finished = 3'b000;
    step();
    attn_done = 1;
    step();
    attn_done = 0;
    fin = 1;
    step();
    fin = 0;
    step();

    // Priority: fin wins over en in IDLE
    fin = 1;
    en = 1;
    step();
    #2 chk("prio_read", phase, 3'd5);
    fin = 0;
    en = 0;
    step();
    #2 chk("prio_idle", phase, 3'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      en = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) == 0) fin = ~fin;
      proj_web = N'($urandom);
      proj_addr = (N*AW)'($urandom);
      for (int b = 0; b < N; b++)
        proj_finished[b] = $urandom_range(0, 7) == 0;
      attn_addr = (N*AW)'($urandom);
      attn_done = $urandom_range(0, 5) == 0;
      fin_addr = AW'($urandom);
      fin_ren = $urandom_range(0, 1) == 1;
      fin_sel = 2'($urandom_range(0, 2));
      step();
    end
    quiet();
    repeat (6) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
